// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM -> WB pipeline register with load formatting and
// alignment checking. One-cycle latency; every output comes from a register.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic [2:0]        load_type,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_AW-1:0] rd_in,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_exc,
    output logic              fwd_we,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_rdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_fmt;
    logic              w_err;
    logic [DATA_W-1:0] w_data;
    logic              w_we;

    logic              r_valid;
    logic              r_we;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic              r_exc;

    // Gate the memory word so an undriven outt on non-loads never reaches the datapath
    always_comb begin
        if (MemRead_in) begin
            w_rdata = mem_rdata;
        end else begin
            w_rdata = {DATA_W{1'b0}};
        end
    end

    // Lane extraction: byte and halfword picked by the low address bits
    always_comb begin
        w_off = alu_result[1:0];
        case (w_off)
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            2'd3:    w_byte = w_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (w_off[1]) begin
            w_half = w_rdata[31:16];
        end else begin
            w_half = w_rdata[15:0];
        end
    end

    // Load formatting and fault detection (misaligned or unknown load type)
    always_comb begin
        w_fmt = w_rdata;
        w_err = 1'b0;
        case (load_type)
            LT_LW: begin
                w_fmt = w_rdata;
                w_err = (w_off != 2'd0);
            end
            LT_LH: begin
                w_fmt = {{(DATA_W-16){w_half[15]}}, w_half};
                w_err = w_off[0];
            end
            LT_LHU: begin
                w_fmt = {{(DATA_W-16){1'b0}}, w_half};
                w_err = w_off[0];
            end
            LT_LB: begin
                w_fmt = {{(DATA_W-8){w_byte[7]}}, w_byte};
                w_err = 1'b0;
            end
            LT_LBU: begin
                w_fmt = {{(DATA_W-8){1'b0}}, w_byte};
                w_err = 1'b0;
            end
            default: begin
                w_fmt = alu_result;
                w_err = 1'b1;
            end
        endcase
        // Only loads can fault; ALU ops ignore load_type entirely
        if (!MemRead_in) begin
            w_err = 1'b0;
        end else begin
            w_err = w_err;
        end
    end

    // Writeback source select and write-enable qualification
    always_comb begin
        if (MemRead_in && MemtoReg_in && !w_err) begin
            w_data = w_fmt;
        end else begin
            w_data = alu_result;
        end
        w_we = in_valid & RegWrite_in & (rd_in != {REG_AW{1'b0}}) & ~w_err;
    end

    // Stage register: reset > flush > stall > capture; invalid input captures a bubble
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= {REG_AW{1'b0}};
            r_data  <= {DATA_W{1'b0}};
            r_exc   <= 1'b0;
        end else if (stall) begin
            r_valid <= r_valid;
            r_we    <= r_we;
            r_rd    <= r_rd;
            r_data  <= r_data;
            r_exc   <= r_exc;
        end else if (!in_valid) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= {REG_AW{1'b0}};
            r_data  <= {DATA_W{1'b0}};
            r_exc   <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            r_we    <= w_we;
            r_rd    <= rd_in;
            r_data  <= w_data;
            r_exc   <= w_err;
        end
    end

    assign wb_valid = r_valid;
    assign wb_we    = r_we;
    assign wb_rd    = r_rd;
    assign wb_data  = r_data;
    assign wb_exc   = r_exc;

    // Forwarding unit sees exactly the retiring bundle
    assign fwd_we   = r_we;
    assign fwd_rd   = r_rd;
    assign fwd_data = r_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed test-plan steps followed by random traffic,
// each cycle compared against a behavioural model of the stage.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic        RegWrite_in, MemtoReg_in, MemRead_in;
    logic [2:0]  load_type;
    logic [31:0] alu_result, mem_rdata;
    logic [4:0]  rd_in;
    logic        wb_valid, wb_we, wb_exc, fwd_we;
    logic [4:0]  wb_rd, fwd_rd;
    logic [31:0] wb_data, fwd_data;

    int errors = 0;
    int checks = 0;

    // expected stage contents
    logic        e_valid, e_we, e_exc;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
        .MemRead_in(MemRead_in), .load_type(load_type), .alu_result(alu_result),
        .mem_rdata(mem_rdata), .rd_in(rd_in),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exc(wb_exc), .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Reference: what the stage should hold after the coming edge
    task automatic model_edge();
        int unsigned off, lane, val;
        bit err;
        if (reset || flush) begin
            e_valid = 1'b0; e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_exc = 1'b0;
        end else if (stall) begin
            // hold
        end else if (!in_valid) begin
            e_valid = 1'b0; e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_exc = 1'b0;
        end else begin
            err = 1'b0;
            val = 0;
            off = alu_result % 4;
            if (MemRead_in) begin
                if (load_type == 3'd0) begin
                    err = (off != 0);
                    val = mem_rdata;
                end else if (load_type == 3'd1 || load_type == 3'd2) begin
                    err = (off % 2) != 0;
                    lane = (mem_rdata >> (16 * (off / 2))) % 65536;
                    val = (load_type == 3'd1 && lane >= 32768) ? lane + 32'hFFFF0000 : lane;
                end else if (load_type == 3'd3 || load_type == 3'd4) begin
                    lane = (mem_rdata >> (8 * off)) % 256;
                    val = (load_type == 3'd3 && lane >= 128) ? lane + 32'hFFFFFF00 : lane;
                end else begin
                    err = 1'b1;
                end
            end
            e_valid = 1'b1;
            e_rd    = rd_in;
            e_exc   = err;
            e_we    = RegWrite_in && (rd_in != 5'd0) && !err;
            e_data  = (MemRead_in && MemtoReg_in && !err) ? val : alu_result;
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        cmp({tag, ".valid"},    {31'd0, wb_valid}, {31'd0, e_valid});
        cmp({tag, ".we"},       {31'd0, wb_we},    {31'd0, e_we});
        cmp({tag, ".rd"},       {27'd0, wb_rd},    {27'd0, e_rd});
        cmp({tag, ".data"},     wb_data,           e_data);
        cmp({tag, ".exc"},      {31'd0, wb_exc},   {31'd0, e_exc});
        cmp({tag, ".fwd_we"},   {31'd0, fwd_we},   {31'd0, e_we});
        cmp({tag, ".fwd_rd"},   {27'd0, fwd_rd},   {27'd0, e_rd});
        cmp({tag, ".fwd_data"}, fwd_data,          e_data);
        cmp({tag, ".noX"}, {31'd0, $isunknown({wb_valid, wb_we, wb_rd, wb_data, wb_exc,
                                               fwd_we, fwd_rd, fwd_data})}, 32'd0);
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge, compare
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic mr,
                          input logic [2:0] lt, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [4:0] rd);
        in_valid = v; RegWrite_in = rw; MemtoReg_in = m2r; MemRead_in = mr;
        load_type = lt; alu_result = alu; mem_rdata = mem; rd_in = rd;
    endtask

    initial begin
        e_valid = 1'b0; e_we = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_exc = 1'b0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;

        // 1. reset with random inputs, then a plain ALU op
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, $urandom, $urandom, 5'd9);
        step("rst0");
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, $urandom, $urandom, 5'd17);
        step("rst1");
        cmp("rst.data_zero", wb_data, 32'd0);
        reset = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'hDEADBEEF, 5'd8);
        step("alu");
        cmp("alu.data", wb_data, 32'h00001234);
        cmp("alu.we", {31'd0, wb_we}, 32'd1);

        // 2. load formatting
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h103, 32'h80FF7F01, 5'd1);
        step("lb3");  cmp("lb3.data", wb_data, 32'hFFFFFF80);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 32'h101, 32'h80FF7F01, 5'd2);
        step("lbu1"); cmp("lbu1.data", wb_data, 32'h0000007F);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 32'h102, 32'h80FF7F01, 5'd3);
        step("lh2");  cmp("lh2.data", wb_data, 32'hFFFF80FF);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 32'h100, 32'h80FF7F01, 5'd4);
        step("lhu0"); cmp("lhu0.data", wb_data, 32'h00007F01);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 32'h100, 32'h80FF7F01, 5'd6);
        step("lw0");  cmp("lw0.data", wb_data, 32'h80FF7F01);

        // 3. X on outt while not loading
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1E, 32'hxxxxxxxx, 5'd7);
        step("xiso"); cmp("xiso.data", wb_data, 32'h0000001E);

        // 4. misalignment (exception lasts one cycle)
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 32'h42, 32'h11223344, 5'd10);
        step("lw_mis"); cmp("lw_mis.exc", {31'd0, wb_exc}, 32'd1);
        cmp("lw_mis.we", {31'd0, wb_we}, 32'd0); cmp("lw_mis.data", wb_data, 32'h42);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 32'h41, 32'h11223344, 5'd11);
        step("lh_mis"); cmp("lh_mis.exc", {31'd0, wb_exc}, 32'd1);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 32'h42, 32'h80FF7F01, 5'd12);
        step("lhu_ok"); cmp("lhu_ok.exc", {31'd0, wb_exc}, 32'd0);
        cmp("lhu_ok.data", wb_data, 32'h000080FF);
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 32'h40, 32'h11223344, 5'd13);
        step("illegal"); cmp("illegal.exc", {31'd0, wb_exc}, 32'd1);

        // 5. stall hold, then stall+flush
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd5);
        step("cap5");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, $urandom, $urandom, 5'd20 + 5'(i));
            step("stall"); cmp("stall.rd", {27'd0, wb_rd}, 32'd5);
        end
        flush = 1'b1;
        step("stflush"); cmp("stflush.valid", {31'd0, wb_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // 6. writes to $0 and invalid input
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 5'd0);
        step("r0"); cmp("r0.we", {31'd0, wb_we}, 32'd0); cmp("r0.valid", {31'd0, wb_valid}, 32'd1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 5'd9);
        step("inv"); cmp("inv.we", {31'd0, wb_we}, 32'd0); cmp("inv.valid", {31'd0, wb_valid}, 32'd0);

        // Random traffic including stalls, flushes and resets
        for (int n = 0; n < 400; n++) begin
            logic mr;
            mr = ($urandom_range(0, 1) == 1);
            set_in(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, mr, 3'($urandom_range(0, 7)),
                   $urandom, $urandom, 5'($urandom_range(0, 31)));
            if (!mr && $urandom_range(0, 1) == 1) mem_rdata = 32'hxxxxxxxx;
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline stage between the data memory and the register-file write port. Each cycle it captures the data memory read word (`outt`), the ALU result and the writeback control for the instruction leaving MEM. It applies load formatting (byte/halfword extract with sign/zero extension), checks alignment, and presents one registered writeback bundle to the register file and the forwarding unit. Latency is one cycle. Stall and flush behaviour is deterministic.

## Interface
- `DATA_W`, 32, datapath width (only 32 supported)
- `REG_AW`, 5, register index width
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `stall` in 1: hold all stage registers
- `flush` in 1: insert a bubble
- `in_valid` in 1: MEM-stage instruction is valid
- `RegWrite_in` in 1: instruction writes a register
- `MemtoReg_in` in 1: writeback source; 1 = memory, 0 = ALU
- `MemRead_in` in 1: instruction is a load (same signal that drives DataMemory `MemRead`)
- `load_type` in 3: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, others illegal
- `alu_result` in 32: ALU result; also the memory address
- `mem_rdata` in 32: DataMemory `outt`
- `rd_in` in 5: destination register
- `wb_valid` out 1: registered valid
- `wb_we` out 1: register-file write enable
- `wb_rd` out 5: write index
- `wb_data` out 32: write data
- `wb_exc` out 1: misaligned or illegal load retired this cycle
- `fwd_we`, `fwd_rd`, `fwd_data` out 1/5/32: copies of `wb_we`/`wb_rd`/`wb_data` for the forwarding unit

## Operation
- **Priority at each rising edge:** `reset` > `flush` > `stall` > normal capture.
- **Reset:** every output register is cleared to 0 (`wb_valid`, `wb_we`, `wb_rd`, `wb_data`, `wb_exc`; the `fwd_*` outputs follow).
- **Flush:** same clear as reset, on that edge only.
- **Stall:** all registers hold their current value, including `wb_exc`. A held exception therefore stays asserted during a stall.
- **Normal capture, source select:**
  - If `MemtoReg_in=1` and `MemRead_in=1`, the source is the formatted memory data.
  - Otherwise the source is `alu_result`.
  - `mem_rdata` is never sampled when `MemRead_in=0`. DataMemory drives X there, and X must not propagate.
- **Load formatting** (little-endian lanes, `off = alu_result[1:0]`):
  - LW: the full word.
  - LB/LBU: byte `mem_rdata[8*off+7 : 8*off]`, sign- or zero-extended to 32 bits.
  - LH/LHU: half `mem_rdata[16*off[1]+15 : 16*off[1]]`, sign- or zero-extended.
- **Alignment error:**
  - Condition: a load (`MemRead_in=1`) with either LW and `off≠0`, or LH/LHU and `off[0]=1`.
  - Result: `wb_exc=1`, `wb_we=0`, `wb_data=alu_result`.
- **Illegal `load_type`:** on a load, sets `wb_exc=1` and `wb_we=0`.
- **Write enable:** `wb_we = in_valid & RegWrite_in & (rd_in≠0) & ~err`, registered. Writes to `$0` are suppressed.
- **Invalid input:** when `in_valid=0`, all control outputs (`wb_valid`, `wb_we`, `wb_exc`) are captured as 0, and data outputs are captured as 0.
- **`fwd_*` outputs:** pure wires from the registered outputs.

## Timing
- Latency: an instruction presented at edge N appears on the outputs from just after edge N until edge N+1. Throughput is one instruction per cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- The register file writes on the same rising edge that retires the bundle, so the bundle must be stable for the whole cycle.
- `stall` and `flush` asserted together: flush wins.
- `reset` asserted mid-stall clears the stage and releases the hold. After `reset` deasserts, the first capture happens on the next edge.
- `wb_exc` stays high for exactly one cycle per faulting instruction, unless a stall holds it.

## Test plan
1. **Reset clear:** hold `reset=1` for 2 edges with random inputs -> all outputs are 0. Release reset, then apply ALU op (`alu_result=0x1234`, `rd=8`, `RegWrite=1`) -> next cycle `wb_we=1`, `wb_rd=8`, `wb_data=0x00001234`.
2. **Load formatting:** `mem_rdata=0x80FF7F01`, `MemRead=MemtoReg=1`. Expected `wb_data`:
   - LB, off=3 -> `0xFFFFFF80`
   - LBU, off=1 -> `0x0000007F`
   - LH, off=2 -> `0xFFFF80FF`
   - LHU, off=0 -> `0x00007F01`
   - LW, off=0 -> `0x80FF7F01`
3. **X isolation:** `mem_rdata=X`, `MemRead=0`, `MemtoReg=0`, `alu_result=0x1E` -> `wb_data=0x0000001E`, with no X on any output.
4. **Misalignment:**
   - LW at `alu_result=0x42` -> `wb_exc=1`, `wb_we=0` for one cycle.
   - LH at `0x41` -> same.
   - LHU at `0x42` -> `wb_exc=0`, write proceeds.
5. **Stall/flush:**
   - Capture `rd=5`, then `stall=1` for 3 cycles with new inputs -> outputs hold `rd=5`.
   - `stall=1` and `flush=1` together -> outputs become 0 next cycle.
6. **`$0` write:** `rd_in=0`, `RegWrite=1`, `in_valid=1` -> `wb_we=0` and `wb_valid=1`. Also `in_valid=0` with `RegWrite=1` -> `wb_we=0` and `wb_valid=0`.
